// File: rtl/pwm_peripheral.sv
// 16-pin PWM/static output driver with a prescaled 8-bit period counter and a double-buffered duty cycle.
// out is registered (1 clk after inputs/counter); no handshake, inputs are sampled every clk.
module pwm_peripheral #(
    parameter int unsigned PRESCALE = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start,
    output logic [7:0]  duty_active
);

    localparam logic [15:0] DIV_MAX = 16'(PRESCALE);

    logic [15:0] div_cnt;
    logic [7:0]  pwm_cnt;
    logic        tick;
    logic        boundary;
    logic        pwm_level;
    logic [15:0] en_out;
    logic [15:0] en_pwm;

    assign en_out   = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign tick     = (div_cnt == DIV_MAX);
    assign boundary = tick && (pwm_cnt == 8'hFF);

    // 0xFF is special-cased so full duty never shows a low tick at the wrap
    assign pwm_level = (duty_active == 8'hFF) || (pwm_cnt < duty_active);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            pwm_cnt <= '0;
        end else begin
            div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;
            if (boundary)
                pwm_cnt <= 8'd0;
            else if (tick)
                pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_active  <= '0;
            period_start <= 1'b0;
        end else begin
            period_start <= boundary;
            if (boundary)
                duty_active <= pwm_duty_cycle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out <= '0;
        else
            out <= en_out & (~en_pwm | {16{pwm_level}});
    end

endmodule
